instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential/redirected fetch into an IF/ID register with a one-entry skid buffer.
// Latency: one cycle from IMemAck to Instr/InstrValid; 1 instr/cycle with zero-wait memory.
// Backpressure: Stall holds IF/ID; an ack arriving under Stall is parked in the skid buffer (HOLD, no request).
//
// Ports:
//   clk, rst                      - single clock, asynchronous active-high reset
//   Stall                         - decode cannot take a new instruction this cycle
//   BranchTaken, BranchTarget     - redirect fetch (target forced word-aligned)
//   IMemReq, IMemAddr             - instruction memory request (decoded from state / ReqAddr)
//   IMemAck, IMemRData            - memory read response
//   Instr, PCPlus4, InstrValid    - IF/ID register toward decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] Instr,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] redir_pc, redir_pc_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic [31:0] instr_n, pc4_n;
    logic        valid_n;

    logic        accept;
    logic [31:0] target;
    logic [31:0] req_addr_inc;

    assign accept       = !InstrValid || !Stall;
    assign target       = {BranchTarget[31:2], 2'b00};
    assign req_addr_inc = req_addr + 32'd4;

    assign IMemReq  = (state == FETCH) || (state == DROP);
    assign IMemAddr = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= RESET_PC;
            redir_pc   <= 32'd0;
            skid_instr <= 32'd0;
            skid_pc4   <= 32'd0;
            Instr      <= 32'd0;
            PCPlus4    <= 32'd0;
            InstrValid <= 1'b0;
        end else begin
            state      <= state_n;
            req_addr   <= req_addr_n;
            redir_pc   <= redir_pc_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
            Instr      <= instr_n;
            PCPlus4    <= pc4_n;
            InstrValid <= valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        req_addr_n   = req_addr;
        redir_pc_n   = redir_pc;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        instr_n      = Instr;
        pc4_n        = PCPlus4;
        valid_n      = InstrValid;

        case (state)
            IDLE: begin
                state_n = FETCH;
                if (BranchTaken) begin
                    valid_n    = 1'b0;
                    req_addr_n = target;
                end else begin
                    req_addr_n = RESET_PC;
                end
            end

            FETCH: begin
                if (BranchTaken) begin
                    valid_n = 1'b0;
                    if (IMemAck) begin
                        // Response completes the request; its data is stale.
                        req_addr_n = target;
                    end else begin
                        // Request still outstanding: finish it in DROP, then go to target.
                        redir_pc_n = target;
                        state_n    = DROP;
                    end
                end else if (IMemAck) begin
                    req_addr_n = req_addr_inc;
                    if (accept) begin
                        instr_n = IMemRData;
                        pc4_n   = req_addr_inc;
                        valid_n = 1'b1;
                    end else begin
                        skid_instr_n = IMemRData;
                        skid_pc4_n   = req_addr_inc;
                        state_n      = HOLD;
                    end
                end else if (accept) begin
                    valid_n = 1'b0;
                end
            end

            HOLD: begin
                if (BranchTaken) begin
                    valid_n    = 1'b0;
                    req_addr_n = target;
                    state_n    = FETCH;
                end else if (!Stall) begin
                    instr_n = skid_instr;
                    pc4_n   = skid_pc4;
                    valid_n = 1'b1;
                    state_n = FETCH;
                end
            end

            DROP: begin
                if (BranchTaken) begin
                    valid_n = 1'b0;
                    if (IMemAck) begin
                        // Newest target wins when the old request completes this same cycle.
                        req_addr_n = target;
                        state_n    = FETCH;
                    end else begin
                        redir_pc_n = target;
                    end
                end else if (IMemAck) begin
                    req_addr_n = redir_pc;
                    state_n    = FETCH;
                end else if (accept) begin
                    valid_n = 1'b0;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
